// File: rtl/time_counter.sv
// Timekeeping stage: divides the system clock to a 1 Hz tick and keeps
// 24-hour BCD time HH:MM:SS, with a set mode for stepping hours and minutes.
module time_counter #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_time,
  input  logic       adj_hour,
  input  logic       adj_min,
  output logic [3:0] o_hour1,
  output logic [3:0] o_hour0,
  output logic [3:0] o_min1,
  output logic [3:0] o_min0,
  output logic [3:0] o_sec1,
  output logic [3:0] o_sec0,
  output logic       o_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescale;
  logic          sec_wrap;
  logic          min_wrap;

  // Two-digit BCD increment modulo 60 (used for both seconds and minutes).
  function automatic logic [7:0] inc_mod60(input logic [3:0] tens, input logic [3:0] units);
    if (units == 4'd9) begin
      if (tens == 4'd5) return 8'h00;
      else              return {tens + 4'd1, 4'd0};
    end
    return {tens, units + 4'd1};
  endfunction

  // Two-digit BCD hour increment modulo 24.
  function automatic logic [7:0] inc_mod24(input logic [3:0] tens, input logic [3:0] units);
    if (tens == 4'd2 && units == 4'd3) return 8'h00;
    if (units == 4'd9)                 return {tens + 4'd1, 4'd0};
    return {tens, units + 4'd1};
  endfunction

  assign sec_wrap = (o_sec1 == 4'd5) && (o_sec0 == 4'd9);
  assign min_wrap = (o_min1 == 4'd5) && (o_min0 == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      o_tick   <= 1'b0;
      o_hour1  <= 4'd0;
      o_hour0  <= 4'd0;
      o_min1   <= 4'd0;
      o_min0   <= 4'd0;
      o_sec1   <= 4'd0;
      o_sec0   <= 4'd0;
    end else if (set_time) begin
      // Set mode: time frozen with seconds cleared; minute and hour step independently.
      prescale <= '0;
      o_tick   <= 1'b0;
      o_sec1   <= 4'd0;
      o_sec0   <= 4'd0;
      if (adj_min)  {o_min1, o_min0}   <= inc_mod60(o_min1, o_min0);
      if (adj_hour) {o_hour1, o_hour0} <= inc_mod24(o_hour1, o_hour0);
    end else if (prescale == PRE_MAX) begin
      prescale <= '0;
      o_tick   <= 1'b1;
      {o_sec1, o_sec0} <= inc_mod60(o_sec1, o_sec0);
      if (sec_wrap)             {o_min1, o_min0}   <= inc_mod60(o_min1, o_min0);
      if (sec_wrap && min_wrap) {o_hour1, o_hour0} <= inc_mod24(o_hour1, o_hour0);
    end else begin
      prescale <= prescale + PW'(1);
      o_tick   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter at CLK_HZ=4: seconds-of-day reference model checked
// every cycle, plus directed literal expectations.
module tb_time_counter;

  localparam int CLK_HZ = 4;

  logic       clk;
  logic       rst_n;
  logic       set_time;
  logic       adj_hour;
  logic       adj_min;
  logic [3:0] o_hour1, o_hour0, o_min1, o_min0, o_sec1, o_sec0;
  logic       o_tick;

  int compared;
  int mismatched;

  // Reference state: time as seconds since midnight, prescale count, tick.
  int tod;
  int cnt;
  bit mtick;

  logic [23:0] dig;
  assign dig = {o_hour1, o_hour0, o_min1, o_min0, o_sec1, o_sec0};

  time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_time(set_time),
    .adj_hour(adj_hour),
    .adj_min (adj_min),
    .o_hour1 (o_hour1),
    .o_hour0 (o_hour0),
    .o_min1  (o_min1),
    .o_min0  (o_min0),
    .o_sec1  (o_sec1),
    .o_sec0  (o_sec0),
    .o_tick  (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin : model
    int h, m;
    if (!rst_n) begin
      tod   <= 0;
      cnt   <= 0;
      mtick <= 1'b0;
    end else if (set_time) begin
      h = tod / 3600;
      m = (tod / 60) % 60;
      if (adj_hour) h = (h + 1) % 24;
      if (adj_min)  m = (m + 1) % 60;
      tod   <= h * 3600 + m * 60;
      cnt   <= 0;
      mtick <= 1'b0;
    end else if (cnt == CLK_HZ - 1) begin
      tod   <= (tod + 1) % 86400;
      cnt   <= 0;
      mtick <= 1'b1;
    end else begin
      cnt   <= cnt + 1;
      mtick <= 1'b0;
    end
  end

  function automatic logic [23:0] to_digits(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Advance one cycle and compare the DUT against the model on the falling edge.
  task automatic cyc();
    @(negedge clk);
    compared++;
    if ({dig, o_tick} !== {to_digits(tod), mtick}) begin
      mismatched++;
      $display("FAIL model_cmp t=%0t: got %h tick %b required %h tick %b",
               $time, dig, o_tick, to_digits(tod), mtick);
    end
  endtask

  task automatic pulse(input bit h, input bit m);
    adj_hour = h;
    adj_min  = m;
    cyc();
    adj_hour = 1'b0;
    adj_min  = 1'b0;
  endtask

  initial begin
    int first;
    int nticks;
    bit seen;
    logic [23:0] prev;

    rst_n = 1'b0; set_time = 1'b0; adj_hour = 1'b0; adj_min = 1'b0;
    compared = 0; mismatched = 0;
    cyc(); cyc();
    chk("reset_digits", {8'h0, dig}, 32'h0);
    chk("reset_tick", {31'h0, o_tick}, 32'h0);

    // 1: free run for 40 cycles
    rst_n = 1'b1;
    first = 0; nticks = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (o_tick) begin
        nticks++;
        if (first == 0) first = i;
      end
    end
    chk("t1_first_tick", first, 4);
    chk("t1_tick_count", nticks, 10);
    chk("t1_time", {8'h0, dig}, 32'h000010);

    // 2: minute stepping in set mode
    set_time = 1'b1;
    seen = 1'b0;
    cyc();
    chk("t2_sec_cleared", {8'h0, dig}, 32'h000000);
    for (int i = 0; i < 59; i++) begin
      pulse(1'b0, 1'b1);
      if (o_tick) seen = 1'b1;
    end
    chk("t2_min59", {8'h0, dig}, 32'h005900);
    pulse(1'b0, 1'b1);
    chk("t2_min_wrap", {8'h0, dig}, 32'h000000);
    chk("t2_no_tick", {31'h0, seen}, 32'h0);

    // 3: hour stepping and digit rollovers
    repeat (9) pulse(1'b1, 1'b0);
    chk("t3_h09", {8'h0, dig}, 32'h090000);
    pulse(1'b1, 1'b0);
    chk("t3_h10", {8'h0, dig}, 32'h100000);
    repeat (9) pulse(1'b1, 1'b0);
    chk("t3_h19", {8'h0, dig}, 32'h190000);
    pulse(1'b1, 1'b0);
    chk("t3_h20", {8'h0, dig}, 32'h200000);
    repeat (3) pulse(1'b1, 1'b0);
    chk("t3_h23", {8'h0, dig}, 32'h230000);
    pulse(1'b1, 1'b0);
    chk("t3_h_wrap", {8'h0, dig}, 32'h000000);

    // 4: midnight rollover from 23:59
    repeat (23) pulse(1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b1);
    chk("t4_set", {8'h0, dig}, 32'h235900);
    set_time = 1'b0;
    prev = '0;
    for (int i = 1; i <= 240; i++) begin
      prev = dig;
      cyc();
    end
    chk("t4_before_midnight", {8'h0, prev}, 32'h235959);
    chk("t4_midnight", {8'h0, dig}, 32'h000000);
    chk("t4_midnight_tick", {31'h0, o_tick}, 32'h1);

    // 5: simultaneous adjust, then pulses ignored in run mode
    set_time = 1'b1;
    cyc();
    repeat (12) pulse(1'b1, 1'b0);
    repeat (34) pulse(1'b0, 1'b1);
    chk("t5_set", {8'h0, dig}, 32'h123400);
    pulse(1'b1, 1'b1);
    chk("t5_both", {8'h0, dig}, 32'h133500);
    set_time = 1'b0;
    for (int i = 0; i < 8; i++) begin
      adj_hour = i[0];
      adj_min  = ~i[0];
      cyc();
    end
    adj_hour = 1'b0; adj_min = 1'b0;
    chk("t5_run_ignores_adj", {8'h0, dig}, 32'h133502);

    // 6: asynchronous reset mid-prescale at 05:06:07
    set_time = 1'b1;
    cyc();
    repeat (16) pulse(1'b1, 1'b0);
    repeat (31) pulse(1'b0, 1'b1);
    set_time = 1'b0;
    repeat (30) cyc();
    chk("t6_pre_reset", {8'h0, dig}, 32'h050607);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_digits", {8'h0, dig}, 32'h000000);
    chk("t6_async_tick", {31'h0, o_tick}, 32'h0);
    cyc();
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (o_tick && first == 0) first = i;
    end
    chk("t6_first_tick", first, 4);
    chk("t6_time", {8'h0, dig}, 32'h000002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
